// File: rtl/mem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_ctrl
// Description : Single-outstanding request controller in front of a
//               synchronous single-port memory. Accepts one read or write
//               request at a time, drives the memory strobes for exactly
//               one cycle, and returns read data through a registered
//               valid/ready response channel. Counts completed writes and
//               completed reads with 8-bit wrapping counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   asynchronous active-high reset
//   req_valid    in   requester presents a request
//   req_ready    out  controller accepts a request this cycle (IDLE only)
//   req_write    in   1 = write, 0 = read
//   req_addr     in   [ADDR_W] target address
//   req_wdata    in   [DATA_W] write data (ignored for reads)
//   rsp_valid    out  read data available on rsp_data
//   rsp_ready    in   requester consumes the response
//   rsp_data     out  [DATA_W] registered read data
//   mem_read     out  memory read strobe
//   mem_write    out  memory write strobe
//   mem_addr     out  [ADDR_W] memory address
//   mem_data_in  out  [DATA_W] memory write data
//   mem_data_out in   [DATA_W] memory read data (registered by the memory)
//   wr_cnt       out  [8] completed writes, wraps 255 -> 0
//   rd_cnt       out  [8] completed reads, wraps 255 -> 0
// ============================================================================
module mem_req_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [7:0]        wr_cnt,
  output logic [7:0]        rd_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    RSP     = 3'd4
  } state_e;

  state_e              state_q,    state_d;
  logic                ready_q,    ready_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [7:0]          wr_cnt_q,   wr_cnt_d;
  logic [7:0]          rd_cnt_q,   rd_cnt_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rsp_data_q <= '0;
      wr_cnt_q   <= 8'd0;
      rd_cnt_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      rsp_data_q <= rsp_data_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    rsp_data_d = rsp_data_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;

    case (state_q)
      IDLE: begin
        // ready_q is only ever high in IDLE, so it doubles as the accept gate.
        // Write data is latched for reads too; it is simply never strobed.
        if (req_valid && ready_q) begin
          mem_addr_d = req_addr;
          mem_data_d = req_wdata;
          state_d    = req_write ? WR : RD;
        end
      end
      WR: begin
        wr_cnt_d = wr_cnt_q + 8'd1;
        state_d  = IDLE;
      end
      RD: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // The memory registered its output on the edge that ended RD.
        rsp_data_d = mem_data_out;
        state_d    = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rd_cnt_d = rd_cnt_q + 8'd1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // req_ready is registered from the next state rather than decoded from the
  // current one, so it stays low while reset is released and only rises on
  // the first clock edge afterwards.
  always_comb begin
    ready_d = (state_d == IDLE);
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready   = ready_q;
  assign mem_write   = (state_q == WR);
  assign mem_read    = (state_q == RD);
  assign rsp_valid   = (state_q == RSP);
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_q;
  assign rsp_data    = rsp_data_q;
  assign wr_cnt      = wr_cnt_q;
  assign rd_cnt      = rd_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_ctrl
// Description : Self-checking bench for mem_req_ctrl. A synchronous memory
//               sits on the memory port; a transaction-level model (array of
//               last-written values plus modulo-256 counters) predicts read
//               data and counts. Directed table vectors, multi-cycle corner
//               sequences and randomized transactions are checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_ctrl;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b0;

  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out = '0;
  logic [7:0]    wr_cnt;
  logic [7:0]    rd_cnt;

  mem_req_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .wr_cnt       (wr_cnt),
    .rd_cnt       (rd_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous memory attached to the controller.
  logic [DW-1:0] mem_arr [32] = '{default: '0};
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_addr] <= mem_data_in;
    if (mem_read)  mem_data_out      <= mem_arr[mem_addr];
  end

  // Reference model: transaction level.
  int model_mem [32] = '{default: 0};
  int exp_wr = 0;
  int exp_rd = 0;

  int compared   = 0;
  int mismatched = 0;
  int n_rd_strobe = 0;
  int n_wr_strobe = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Strobe monitor and exclusivity assertion, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_read)  n_rd_strobe++;
    if (mem_write) n_wr_strobe++;
    compared++;
    assert (!(mem_read && mem_write)) else begin
      mismatched++;
      $display("FAIL strobe_exclusive: mem_read=%0b mem_write=%0b, required not both 1 (t=%0t)",
               mem_read, mem_write, $time);
    end
  end

  // All bench activity happens 2ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (!req_ready) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},   {31'd0, req_ready},   32'd0);
    check({tag, "_mem_read"},    {31'd0, mem_read},    32'd0);
    check({tag, "_mem_write"},   {31'd0, mem_write},   32'd0);
    check({tag, "_mem_addr"},    {27'd0, mem_addr},    32'd0);
    check({tag, "_mem_data_in"}, {24'd0, mem_data_in}, 32'd0);
    check({tag, "_rsp_valid"},   {31'd0, rsp_valid},   32'd0);
    check({tag, "_rsp_data"},    {24'd0, rsp_data},    32'd0);
    check({tag, "_wr_cnt"},      {24'd0, wr_cnt},      32'd0);
    check({tag, "_rd_cnt"},      {24'd0, rd_cnt},      32'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    step();                                   // handshake edge N
    req_valid = 1'b0; req_write = 1'b0;
    check("wr_strobe",    {31'd0, mem_write}, 32'd1);
    check("wr_no_read",   {31'd0, mem_read},  32'd0);
    check("wr_addr",      {27'd0, mem_addr},  {27'd0, a});
    check("wr_data",      {24'd0, mem_data_in}, {24'd0, d});
    check("wr_ready_low", {31'd0, req_ready}, 32'd0);
    model_mem[a] = int'(d);
    exp_wr = (exp_wr + 1) % 256;
    step();                                   // commit edge N+1
    check("wr_ready_back", {31'd0, req_ready}, 32'd1);
    check("wr_strobe_off", {31'd0, mem_write}, 32'd0);
    check("wr_cnt",        {24'd0, wr_cnt},    exp_wr);
  endtask

  // hold: RSP cycles with rsp_ready low (0 = already high on entry)
  // spam: keep req_valid asserted with random addresses while busy
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                         input int hold, input bit spam);
    int rs0, ws0;
    wait_ready();
    rs0 = n_rd_strobe; ws0 = n_wr_strobe;
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = DW'($urandom);
    step();                                   // handshake edge N (-> RD)
    if (spam) begin
      req_addr = AW'($urandom); req_write = 1'($urandom);
    end else begin
      req_valid = 1'b0;
    end
    check("rd_strobe",    {31'd0, mem_read},  32'd1);
    check("rd_addr",      {27'd0, mem_addr},  {27'd0, a});
    check("rd_ready_low", {31'd0, req_ready}, 32'd0);
    check("rd_valid_early", {31'd0, rsp_valid}, 32'd0);
    step();                                   // edge N+1 (-> RD_WAIT)
    if (spam) req_addr = AW'($urandom);
    check("rdw_strobe_off", {31'd0, mem_read},  32'd0);
    check("rdw_valid_low",  {31'd0, rsp_valid}, 32'd0);
    step();                                   // edge N+2 (-> RSP); valid seen at edge N+3
    check("rsp_valid",     {31'd0, rsp_valid}, 32'd1);
    check("rsp_data",      {24'd0, rsp_data},  {24'd0, exp});
    check("rsp_addr_hold", {27'd0, mem_addr},  {27'd0, a});
    for (int k = 0; k < hold; k++) begin
      step();
      if (spam) req_addr = AW'($urandom);
      check("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("rsp_hold_data",  {24'd0, rsp_data},  {24'd0, exp});
      check("rsp_hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();                                   // consuming edge
    req_valid = 1'b0;
    exp_rd = (exp_rd + 1) % 256;
    check("rsp_done_valid", {31'd0, rsp_valid}, 32'd0);
    check("rsp_done_ready", {31'd0, req_ready}, 32'd1);
    check("rd_cnt",         {24'd0, rd_cnt},    exp_rd);
    step();
    check("rd_no_second_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rd_strobe_count",  n_rd_strobe - rs0, 32'd1);
    check("rd_no_wr_strobe",  n_wr_strobe - ws0, 32'd0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    exp_wr = 0;
    exp_rd = 0;
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;     // write data, or expected read data
    int            hold;
    bit            spam;
    logic [7:0]    exp_wr_cnt;
    logic [7:0]    exp_rd_cnt;
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    int            ai;

    vecs[0] = '{1'b1, 5'd3,  8'hA5, 0, 1'b0, 8'd1, 8'd0};
    vecs[1] = '{1'b0, 5'd3,  8'hA5, 0, 1'b0, 8'd1, 8'd1};
    vecs[2] = '{1'b1, 5'd0,  8'h11, 0, 1'b0, 8'd2, 8'd1};
    vecs[3] = '{1'b1, 5'd31, 8'hEE, 0, 1'b0, 8'd3, 8'd1};
    vecs[4] = '{1'b0, 5'd0,  8'h11, 0, 1'b0, 8'd3, 8'd2};
    vecs[5] = '{1'b0, 5'd31, 8'hEE, 0, 1'b0, 8'd3, 8'd3};
    vecs[6] = '{1'b0, 5'd3,  8'hA5, 5, 1'b0, 8'd3, 8'd4};
    vecs[7] = '{1'b0, 5'd31, 8'hEE, 1, 1'b1, 8'd3, 8'd5};
    vecs[8] = '{1'b1, 5'd31, 8'h00, 0, 1'b0, 8'd4, 8'd5};
    vecs[9] = '{1'b0, 5'd31, 8'h00, 2, 1'b1, 8'd4, 8'd6};

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0;
    #1;
    check("ready_low_after_rst_release", {31'd0, req_ready}, 32'd0);
    step();
    check("ready_first_edge", {31'd0, req_ready}, 32'd1);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
      else            do_read(vecs[i].addr, vecs[i].data, vecs[i].hold, vecs[i].spam);
      check("vec_wr_cnt", {24'd0, wr_cnt}, {24'd0, vecs[i].exp_wr_cnt});
      check("vec_rd_cnt", {24'd0, rd_cnt}, {24'd0, vecs[i].exp_rd_cnt});
    end

    // Reset asserted during RD_WAIT
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd3;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    check("rst_hold_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_hold_rd_cnt", {24'd0, rd_cnt}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_rel_ready_low", {31'd0, req_ready}, 32'd0);
    step();
    check("rst_rel_ready_high", {31'd0, req_ready}, 32'd1);
    check("rst_rel_no_rsp",     {31'd0, rsp_valid}, 32'd0);
    exp_wr = 0;
    exp_rd = 0;
    do_write(5'd9, 8'h5A);
    do_read(5'd9, 8'h5A, 0, 1'b0);

    // Randomized transactions against the model
    for (int i = 0; i < 200; i++) begin
      ai = int'($urandom_range(0, 31));
      ra = ai[AW-1:0];
      if ($urandom_range(0, 1) == 1) begin
        do_write(ra, DW'($urandom));
      end else begin
        rd = DW'(model_mem[ai]);
        do_read(ra, rd, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      end
    end

    // Write counter wrap
    reset_pulse();
    for (int i = 0; i < 256; i++) begin
      do_write(AW'(i), DW'(i ^ 8'h3C));
      if (i == 254) check("wr_cnt_255", {24'd0, wr_cnt}, 32'd255);
    end
    check("wr_cnt_wrap", {24'd0, wr_cnt}, 32'd0);
    do_read(5'd31, 8'hFF ^ 8'h3C, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
